// File: rtl/asic_readout_sequencer_pkg.sv
// Shared definitions for the ASIC readout sequencer: FSM encoding, frame words
// and the trailer layout.
package asic_readout_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HEADER    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_CHIP = 3'd3,
    S_TRAILER   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [15:0] DEFAULT_HEADER_WORD = 16'hA55A;
  localparam logic [3:0]  TRAILER_TAG         = 4'hC;

  localparam int TRL_TAG_LSB      = 12;
  localparam int TRL_TIMEOUT_BIT  = 11;
  localparam int TRL_OVERFLOW_BIT = 10;
  localparam int TRL_CHIPS_LSB    = 0;

  // Trailer: {tag, timeout, overflow, 2'b00, chips_read}
  function automatic logic [15:0] build_trailer(input logic       timeout,
                                                input logic       overflow,
                                                input logic [7:0] chips);
    logic [15:0] w;
    w                          = '0;
    w[TRL_TAG_LSB +: 4]        = TRAILER_TAG;
    w[TRL_TIMEOUT_BIT]         = timeout;
    w[TRL_OVERFLOW_BIT]        = overflow;
    w[TRL_CHIPS_LSB +: 8]      = chips;
    return w;
  endfunction

endpackage

// File: rtl/asic_readout_sequencer_watchdog.sv
// Readout watchdog: down-counter reloaded while disabled or on activity,
// flags expiry on the TIMEOUT_CYCLES-th consecutive idle enabled cycle.
module asic_readout_sequencer_watchdog #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  logic [15:0] r_cnt;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= TIMEOUT_CYCLES - 16'd1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_expired = i_en && !i_clr && (r_cnt == '0);

endmodule

// File: rtl/asic_readout_sequencer.sv
// Frames one daisy-chain readout (header, pass-through data, trailer) into the
// external FIFO and pulses StartReadout to the chain head.
//   state       | meaning
//   S_IDLE      | waiting for ReadoutStart
//   S_HEADER    | write header word once FIFO has room
//   S_START     | StartReadout high for START_PULSE_CYCLES
//   S_WAIT_CHIP | forward chain data, count ReadDone, watchdog armed
//   S_TRAILER   | write status trailer once FIFO has room and no data pending
//   S_DONE      | one-cycle Done pulse
module asic_readout_sequencer
  import asic_readout_sequencer_pkg::*;
#(
  parameter int          ASIC_NUM           = 4,
  parameter int          START_PULSE_CYCLES = 4,
  parameter int          TIMEOUT_CYCLES     = 50000,
  parameter logic [15:0] HEADER_WORD        = DEFAULT_HEADER_WORD
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        ReadoutStart,
  input  logic [15:0] ReadDataIn,
  input  logic        ReadDataWriteEn,
  input  logic        ReadDone,
  input  logic        EndReadout,
  input  logic        ExternalFifoFull,
  output logic        StartReadout,
  output logic [15:0] ExternalFifoData,
  output logic        ExternalFifoWriteEn,
  output logic        Busy,
  output logic        Done,
  output logic        TimeoutError
);

  localparam logic [7:0] CHIPS_TARGET = 8'(ASIC_NUM);
  localparam logic [3:0] PULSE_LOAD   = 4'(START_PULSE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_pulse_cnt;
  logic [7:0]  r_chips;
  logic        r_overflow;
  logic        r_timeout;
  logic [15:0] r_pass_data;
  logic        r_pass_wen;

  logic        w_in_wait;
  logic        w_wd_clr;
  logic        w_wd_expired;
  logic [7:0]  w_chips_next;
  logic        w_exit;
  logic        w_hdr_wr;
  logic        w_trl_wr;
  logic [15:0] w_trailer;

  assign w_in_wait    = (r_state == S_WAIT_CHIP);
  assign w_wd_clr     = ReadDataWriteEn || ReadDone;
  assign w_chips_next = (ReadDone && (r_chips != 8'hFF)) ? r_chips + 8'd1 : r_chips;
  assign w_exit       = EndReadout || (w_chips_next >= CHIPS_TARGET) || w_wd_expired;
  assign w_trailer    = build_trailer(r_timeout, r_overflow, r_chips);

  asic_readout_sequencer_watchdog #(
    .TIMEOUT_CYCLES (16'(TIMEOUT_CYCLES))
  ) u_readout_watchdog (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .i_en      (w_in_wait),
    .i_clr     (w_wd_clr),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hdr_wr     = 1'b0;
    w_trl_wr     = 1'b0;
    case (r_state)
      S_IDLE:      if (ReadoutStart) w_state_next = S_HEADER;
      S_HEADER: begin
        if (!ExternalFifoFull) begin
          w_hdr_wr     = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START:     if (r_pulse_cnt == '0) w_state_next = S_WAIT_CHIP;
      S_WAIT_CHIP: if (w_exit) w_state_next = S_TRAILER;
      // a data word registered on the exit edge goes out first
      S_TRAILER: begin
        if (!ExternalFifoFull && !r_pass_wen) begin
          w_trl_wr     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse_cnt <= '0;
      r_chips     <= '0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
      r_pass_data <= '0;
      r_pass_wen  <= 1'b0;
    end else begin
      r_pass_wen <= w_in_wait && ReadDataWriteEn && !ExternalFifoFull;
      if (w_in_wait && ReadDataWriteEn) r_pass_data <= ReadDataIn;

      if (w_hdr_wr) begin
        r_pulse_cnt <= PULSE_LOAD;
      end else if ((r_state == S_START) && (r_pulse_cnt != '0)) begin
        r_pulse_cnt <= r_pulse_cnt - 4'd1;
      end

      if ((r_state == S_IDLE) && ReadoutStart) begin
        r_chips    <= '0;
        r_overflow <= 1'b0;
        r_timeout  <= 1'b0;
      end else if (w_in_wait) begin
        r_chips <= w_chips_next;
        if (ReadDataWriteEn && ExternalFifoFull) r_overflow <= 1'b1;
        if (w_wd_expired)                        r_timeout  <= 1'b1;
      end
    end
  end

  assign StartReadout        = (r_state == S_START);
  assign Busy                = (r_state != S_IDLE);
  assign Done                = (r_state == S_DONE);
  assign TimeoutError        = r_timeout;
  assign ExternalFifoWriteEn = w_hdr_wr || w_trl_wr || r_pass_wen;
  assign ExternalFifoData    = w_hdr_wr ? HEADER_WORD :
                               w_trl_wr ? w_trailer   : r_pass_data;

endmodule

// File: doc/asic_readout_sequencer.md
# asic_readout_sequencer

Sequences one full readout of the ASIC daisy chain after an acquisition: frames the data stream with header and trailer words, issues StartReadout to the chain head, and forwards the 16-bit words produced by the serial RAM readout block into the external FIFO. It is the sole writer of the external FIFO. It arbitrates between its own framing words and the readout datapath, and guards the sequence with a watchdog timeout. It sits between the DIF acquisition control and the AsicRamReadout path / USB FIFO.

## Interface
- ASIC_NUM, 4: ASICs in the chain (1..255)
- START_PULSE_CYCLES, 4: StartReadout high time in Clk cycles (1..15)
- TIMEOUT_CYCLES, 50000: idle cycles tolerated in WAIT_CHIP (16-bit)
- HEADER_WORD, 16'hA55A: first word of every frame
- Clk  in  1  single clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- ReadoutStart  in  1  one-cycle request; honoured only in IDLE
- ReadDataIn  in  16  word from readout datapath
- ReadDataWriteEn  in  1  ReadDataIn valid, one cycle per word
- ReadDone  in  1  one-cycle pulse per finished ASIC burst
- EndReadout  in  1  chain-end flag, sampled high = chain finished
- ExternalFifoFull  in  1  FIFO cannot accept a word this cycle
- StartReadout  out  1  chain start pulse
- ExternalFifoData  out  16  FIFO write data
- ExternalFifoWriteEn  out  1  FIFO write strobe
- Busy  out  1  high from HEADER through DONE
- Done  out  1  one-cycle pulse at frame end
- TimeoutError  out  1  sticky until next accepted ReadoutStart

## Operation
- Reset values: all outputs 0; state IDLE; ChipsRead, counters and flags 0.
- States: IDLE, HEADER, START, WAIT_CHIP, TRAILER, DONE.
- IDLE: on ReadoutStart, go to HEADER and clear ChipsRead, OverflowFlag and TimeoutError. Otherwise stay.
- HEADER: wait while ExternalFifoFull. When not full, write HEADER_WORD for one cycle and go to START.
- START: StartReadout is high for exactly START_PULSE_CYCLES, then WAIT_CHIP.
- WAIT_CHIP: registered pass-through. ExternalFifoData <= ReadDataIn; ExternalFifoWriteEn <= ReadDataWriteEn & ~ExternalFifoFull.
  - A word arriving while full is dropped and sets OverflowFlag.
  - ReadDone increments ChipsRead (8-bit, saturates at 255).
  - Exit to TRAILER on the first of: EndReadout; ChipsRead reaching ASIC_NUM; watchdog expiry.
- Watchdog: counts cycles in WAIT_CHIP, cleared by ReadDataWriteEn or ReadDone. Reaching TIMEOUT_CYCLES sets TimeoutError and exits.
- TRAILER: wait while full. Then write {4'hC, TimeoutError, OverflowFlag, 2'b00, ChipsRead} and go to DONE.
- DONE: Done=1 for one cycle, then IDLE.
- ReadoutStart outside IDLE is ignored and not queued.

## Timing
- ReadoutStart at edge n: Busy=1 and state HEADER from n+1; header written at n+1 if not full.
- StartReadout rises one cycle after the header write.
- Data pass-through latency is 1 cycle; no words are lost while the FIFO is not full.
- Word and exit condition in the same cycle: the word is still written, and the trailer follows on the next cycle. The trailer never overlaps a data write.
- ReadDone coincident with EndReadout: ReadDone is counted before the trailer is built.
- reset_n low mid-frame: StartReadout, WriteEn and Busy drop immediately (asynchronous). No trailer is written.
- Done and Busy fall together on leaving DONE.

## Structure
- Shared package: state encoding; trailer tag 4'hC and field positions; default HEADER_WORD.
- One sub-module, readout_watchdog: 16-bit counter with enable, clear, and an expired flag.
- Output mux between framing words and pass-through data lives in the top module.

## Test plan
- ASIC_NUM=4, ReadoutStart, 4 ASICs each giving 3 words plus ReadDone -> FIFO gets A55A, 12 data words in order, C004. Done pulses once. StartReadout is high 4 cycles.
- EndReadout after 2 ReadDone -> trailer C002, no timeout.
- No data after StartReadout, TIMEOUT_CYCLES=100 -> TimeoutError at cycle 100 of WAIT_CHIP, trailer C800.
- ExternalFifoFull held during HEADER for 10 cycles, then 1 cycle during a data word -> header delayed 10 cycles, that word dropped, trailer bit 10 set (C4nn).
- reset_n pulsed low mid-WAIT_CHIP -> outputs 0 immediately. A new ReadoutStart then gives a clean frame starting A55A.
- ReadoutStart pulsed during WAIT_CHIP -> ignored; exactly one header per frame.
